// File: rtl/traceback_engine_if.sv
// Bundles the matrix-memory read port and the outgoing move stream of the traceback engine.
interface traceback_engine_if #(
    parameter int SEQ_LENGTH_W     = 4,
    parameter int SOURCE_WIDTH     = 2,
    parameter int DATA_PACKET_SIZE = 3
);
    logic                        mem_rd_en;
    logic [2*SEQ_LENGTH_W-1:0]   mem_rd_addr;
    logic [DATA_PACKET_SIZE-1:0] mem_rd_data;
    logic                        op_valid;
    logic                        op_ready;
    logic [SOURCE_WIDTH-1:0]     op_code;
    logic [SEQ_LENGTH_W-1:0]     op_row;
    logic [SEQ_LENGTH_W-1:0]     op_col;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output op_valid, op_code, op_row, op_col,
        input  op_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  op_valid, op_code, op_row, op_col,
        output op_ready
    );
endinterface

// File: rtl/traceback_engine.sv
// Walks the stored source codes backward from the max-score cell and streams
// the local-alignment moves, last cell first, over a ready/valid port.
module traceback_engine #(
    parameter int SEQ_LENGTH       = 16,
    parameter int SEQ_LENGTH_W     = 4,
    parameter int SOURCE_WIDTH     = 2,
    parameter int DATA_PACKET_SIZE = 3,
    parameter int PATH_W           = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SEQ_LENGTH_W-1:0] max_row,
    input  logic [SEQ_LENGTH_W-1:0] max_col,
    traceback_engine_if.master      bus,
    output logic                    busy,
    output logic                    done,
    output logic [PATH_W-1:0]       path_len,
    output logic                    error
);

    localparam int ADDR_W = 2 * SEQ_LENGTH_W;

    localparam logic [SOURCE_WIDTH-1:0] SRC_DIAG    = SOURCE_WIDTH'(0);
    localparam logic [SOURCE_WIDTH-1:0] SRC_TOP     = SOURCE_WIDTH'(1);
    localparam logic [SOURCE_WIDTH-1:0] SRC_ILLEGAL = SOURCE_WIDTH'(3);
    localparam logic [PATH_W-1:0]       PATH_MAX    = '1;
    localparam logic [SEQ_LENGTH_W-1:0] IDX_ONE     = SEQ_LENGTH_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SEQ_LENGTH_W-1:0] cur_row_q, cur_row_d;
    logic [SEQ_LENGTH_W-1:0] cur_col_q, cur_col_d;
    logic [SOURCE_WIDTH-1:0] code_q, code_d;
    logic [PATH_W-1:0]       path_len_q, path_len_d;
    logic                    error_q, error_d;

    logic                    rd_en;
    logic                    op_valid;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    pkt_zero;
    logic [SOURCE_WIDTH-1:0] pkt_src;

    assign pkt_zero = bus.mem_rd_data[DATA_PACKET_SIZE-1];
    assign pkt_src  = bus.mem_rd_data[SOURCE_WIDTH-1:0];

    // True when taking the move would step off row 0 or column 0.
    function automatic logic step_exits(input logic [SOURCE_WIDTH-1:0] code,
                                        input logic [SEQ_LENGTH_W-1:0] row,
                                        input logic [SEQ_LENGTH_W-1:0] col);
        logic exits;
        case (code)
            SRC_DIAG: exits = (row == '0) || (col == '0);
            SRC_TOP:  exits = (row == '0);
            default:  exits = (col == '0);
        endcase
        return exits;
    endfunction

    function automatic logic [PATH_W-1:0] sat_inc(input logic [PATH_W-1:0] val);
        return (val == PATH_MAX) ? val : val + PATH_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        code_d     = code_q;
        path_len_d = path_len_q;
        error_d    = error_q;
        rd_en      = 1'b0;
        op_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_row_d  = max_row;
                    cur_col_d  = max_col;
                    path_len_d = '0;
                    error_d    = 1'b0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                rd_en   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A zero cell ends the local alignment and is never emitted.
                if (pkt_zero) begin
                    state_d = S_DONE;
                end else if (pkt_src == SRC_ILLEGAL) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    code_d  = pkt_src;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                op_valid = 1'b1;
                if (bus.op_ready) begin
                    path_len_d = sat_inc(path_len_q);
                    if (step_exits(code_q, cur_row_q, cur_col_q)) begin
                        state_d = S_DONE;
                    end else begin
                        case (code_q)
                            SRC_DIAG: begin
                                cur_row_d = cur_row_q - IDX_ONE;
                                cur_col_d = cur_col_q - IDX_ONE;
                            end
                            SRC_TOP:  cur_row_d = cur_row_q - IDX_ONE;
                            default:  cur_col_d = cur_col_q - IDX_ONE;
                        endcase
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            code_q     <= '0;
            path_len_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            code_q     <= code_d;
            path_len_q <= path_len_d;
            error_q    <= error_d;
        end
    end

    // Address is driven only with the strobe so the bus idles at zero.
    always_comb begin
        rd_addr = '0;
        if (rd_en) begin
            rd_addr = ADDR_W'(cur_row_q) * ADDR_W'(SEQ_LENGTH) + ADDR_W'(cur_col_q);
        end
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.op_valid    = op_valid;
    assign bus.op_code     = code_q;
    assign bus.op_row      = cur_row_q;
    assign bus.op_col      = cur_col_q;

    assign busy     = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_EMIT);
    assign done     = (state_q == S_DONE);
    assign path_len = path_len_q;
    assign error    = error_q;

endmodule

// File: tb/tb_traceback_engine.sv
// Bench for traceback_engine: directed table, hand-written corner sequences and
// randomized matrices checked against a path-walking reference model.
module tb_traceback_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] max_row;
    logic [3:0] max_col;
    logic       busy;
    logic       done;
    logic [5:0] path_len;
    logic       error;

    traceback_engine_if #(.SEQ_LENGTH_W(4), .SOURCE_WIDTH(2), .DATA_PACKET_SIZE(3)) bus_if ();

    traceback_engine #(
        .SEQ_LENGTH(16), .SEQ_LENGTH_W(4), .SOURCE_WIDTH(2), .DATA_PACKET_SIZE(3), .PATH_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_row(max_row), .max_col(max_col),
        .bus(bus_if), .busy(busy), .done(done), .path_len(path_len), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] mem [256];

    // Registered read: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus_if.mem_rd_en) bus_if.mem_rd_data <= mem[bus_if.mem_rd_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] exp_ops[$];
    logic [9:0] got_ops[$];
    int         exp_reads[$];
    int         got_reads[$];
    int         exp_len, exp_err;
    int         got_len, got_err;
    int         done_cyc, first_rd, first_vld;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: follow the source codes cell by cell with plain index arithmetic.
    task automatic model(input int r0, input int c0);
        int r, c;
        logic [2:0] p;
        exp_ops.delete();
        exp_reads.delete();
        exp_len = 0;
        exp_err = 0;
        r = r0;
        c = c0;
        forever begin
            exp_reads.push_back(r * 16 + c);
            p = mem[r * 16 + c];
            if (p[2]) break;
            if (p[1:0] == 2'd3) begin
                exp_err = 1;
                break;
            end
            exp_ops.push_back({p[1:0], 4'(r), 4'(c)});
            exp_len++;
            if (p[1:0] == 2'd0) begin
                if (r == 0 || c == 0) break;
                r--; c--;
            end else if (p[1:0] == 2'd1) begin
                if (r == 0) break;
                r--;
            end else begin
                if (c == 0) break;
                c--;
            end
        end
    endtask

    task automatic setup_mem(input int id);
        for (int i = 0; i < 256; i++) mem[i] = 3'b100;
        case (id)
            0: begin mem[51] = 3'b000; mem[34] = 3'b000; mem[17] = 3'b000; end
            1: begin mem[35] = 3'b010; mem[34] = 3'b001; mem[18] = 3'b000; end
            2: begin mem[2] = 3'b010; mem[1] = 3'b010; mem[0] = 3'b010; end
            3: mem[87] = 3'b011;
            default: ;
        endcase
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 63);
            if (r < 6)       mem[i] = {1'b1, 2'($urandom_range(0, 3))};
            else if (r == 6) mem[i] = 3'b011;
            else             mem[i] = {1'b0, 2'($urandom_range(0, 2))};
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low for the first 5 cycles of the first op.
    task automatic run_case(input logic [3:0] mr, input logic [3:0] mc, input int mode, input bit busy_start);
        int cyc;
        bit saw_done, prev_stall;
        logic [9:0] prev_fields;
        model(mr, mc);
        got_ops.delete();
        got_reads.delete();
        got_len = -1; got_err = -1; done_cyc = -1; first_rd = -1; first_vld = -1;
        saw_done = 0; prev_stall = 0; prev_fields = '0;
        @(negedge clk);
        start = 1'b1; max_row = mr; max_col = mc;
        bus_if.op_ready = (mode == 0);
        cyc = 0;
        while (!saw_done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy_start && cyc == 2) begin
                start = 1'b1; max_row = 4'd7; max_col = 4'd7;
            end
            case (mode)
                0: bus_if.op_ready = 1'b1;
                1: bus_if.op_ready = ($urandom_range(0, 2) != 0);
                default: bus_if.op_ready = (first_vld >= 0) && (cyc >= first_vld + 5);
            endcase
            #1;
            if (prev_stall) begin
                check("stall_hold_valid", int'(bus_if.op_valid), 1);
                check("stall_hold_fields", int'({bus_if.op_code, bus_if.op_row, bus_if.op_col}), int'(prev_fields));
                check("stall_no_read", int'(bus_if.mem_rd_en), 0);
            end
            check("busy_level", int'(busy), int'(!done));
            if (bus_if.mem_rd_en) begin
                got_reads.push_back(int'(bus_if.mem_rd_addr));
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus_if.op_valid && first_vld < 0) first_vld = cyc;
            if (bus_if.op_valid && bus_if.op_ready)
                got_ops.push_back({bus_if.op_code, bus_if.op_row, bus_if.op_col});
            prev_stall  = bus_if.op_valid && !bus_if.op_ready;
            prev_fields = {bus_if.op_code, bus_if.op_row, bus_if.op_col};
            if (done) begin
                saw_done = 1; done_cyc = cyc;
                got_len = int'(path_len); got_err = int'(error);
            end
        end
        if (!saw_done) check("done_timeout", 0, 1);
        check("n_ops", got_ops.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++)
            check("op_fields", int'(got_ops[i]), int'(exp_ops[i]));
        check("n_reads", got_reads.size(), exp_reads.size());
        for (int i = 0; i < exp_reads.size() && i < got_reads.size(); i++)
            check("read_addr", got_reads[i], exp_reads[i]);
        check("path_len", got_len, exp_len);
        check("error", got_err, exp_err);
        @(negedge clk);
        #1;
        check("done_one_cycle", int'({done, busy}), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, int'({busy, done, error, bus_if.op_valid, bus_if.mem_rd_en}), 0);
        check({tag, "_path_len"}, int'(path_len), 0);
        check({tag, "_addr"}, int'(bus_if.mem_rd_addr), 0);
        check({tag, "_op"}, int'({bus_if.op_code, bus_if.op_row, bus_if.op_col}), 0);
    endtask

    typedef struct {
        int         id;
        logic [3:0] mr;
        logic [3:0] mc;
        int         len;
        int         err;
        int         nrd;
        int         last;
        logic [5:0] codes;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int base_done;
        bit seen;
        tbl[0] = '{0, 4'd3, 4'd3, 3, 0, 4, 0,   6'b00_00_00};
        tbl[1] = '{1, 4'd2, 4'd3, 3, 0, 4, 1,   6'b10_01_00};
        tbl[2] = '{2, 4'd0, 4'd2, 3, 0, 3, 0,   6'b10_10_10};
        tbl[3] = '{3, 4'd5, 4'd7, 0, 1, 1, 87,  6'b00_00_00};
        tbl[4] = '{4, 4'd9, 4'd9, 0, 0, 1, 153, 6'b00_00_00};
        base_done = -1;

        rst_n = 1'b0; start = 1'b0; max_row = '0; max_col = '0; bus_if.op_ready = 1'b0;
        setup_mem(4);
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            setup_mem(tbl[t].id);
            run_case(tbl[t].mr, tbl[t].mc, 0, 0);
            check("tbl_len", got_len, tbl[t].len);
            check("tbl_err", got_err, tbl[t].err);
            check("tbl_nreads", got_reads.size(), tbl[t].nrd);
            check("tbl_last_addr", (got_reads.size() > 0) ? got_reads[got_reads.size()-1] : -1, tbl[t].last);
            for (int k = 0; k < tbl[t].len; k++)
                check("tbl_code", (k < got_ops.size()) ? int'(got_ops[k][9:8]) : -1,
                      int'(tbl[t].codes[5 - 2*k -: 2]));
            if (tbl[t].len == 0) check("tbl_no_valid", first_vld, -1);
            if (tbl[t].id == 0) begin
                check("lat_first_read", first_rd, 1);
                check("lat_first_valid", first_vld, 3);
                base_done = done_cyc;
            end
            if (tbl[t].id == 3) begin
                repeat (3) @(negedge clk);
                #1;
                check("error_sticky", int'(error), 1);
            end
        end

        setup_mem(0);
        run_case(4'd3, 4'd3, 2, 0);
        check("stall_latency", done_cyc, base_done + 5);
        check("stall_first_valid", first_vld, 3);

        setup_mem(0);
        run_case(4'd3, 4'd3, 0, 1);
        check("busy_start_len", got_len, 3);

        setup_mem(0);
        @(negedge clk);
        start = 1'b1; max_row = 4'd3; max_col = 4'd3; bus_if.op_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus_if.op_valid;
        end
        check("rst_reach_emit", int'(seen), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_emit");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_idle", int'({done, busy, bus_if.op_valid, bus_if.mem_rd_en}), 0);
        end
        run_case(4'd3, 4'd3, 0, 0);

        for (int n = 0; n < 40; n++) begin
            fill_random();
            run_case(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traceback_engine.md
Name: traceback_engine

Overview:
- Reader side of the matrix memory: walks the stored per-cell data packets (zero-score bit plus source code) backward from the maximum-score cell.
- The matrix calculation stage writes those packets.
- Emits the local alignment path as a ready/valid stream of moves, last cell first, for the downstream alignment formatter.
- Started by the controller once the max registers hold the final maximum-cell coordinates.

Parameters:
- SEQ_LENGTH, 16, letters per sequence; the matrix is SEQ_LENGTH x SEQ_LENGTH.
- SEQ_LENGTH_W, 4, row/column index width, $clog2(SEQ_LENGTH).
- SOURCE_WIDTH, 2, source field width.
- DATA_PACKET_SIZE, 3, packet width = {zero_bit, source}.
- PATH_W, 6, path length counter width (SEQ_LENGTH_W+2).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse to begin traceback; honoured only in IDLE.
- max_row, in, SEQ_LENGTH_W, row of the max-score cell; sampled with start.
- max_col, in, SEQ_LENGTH_W, column of the max-score cell; sampled with start.
- mem_rd_en, out, 1, matrix memory read strobe.
- mem_rd_addr, out, 2*SEQ_LENGTH_W, read address = row*SEQ_LENGTH + col.
- mem_rd_data, in, DATA_PACKET_SIZE, packet returned exactly 1 cycle after mem_rd_en.
- op_valid, out, 1, move output valid.
- op_ready, in, 1, downstream accepts the move.
- op_code, out, SOURCE_WIDTH, 0 = diagonal (match/mismatch), 1 = top (gap in database), 2 = left (gap in query).
- op_row, out, SEQ_LENGTH_W, row of the cell the move belongs to.
- op_col, out, SEQ_LENGTH_W, column of that cell.
- busy, out, 1, high from the cycle after an accepted start until DONE exits.
- done, out, 1, one-cycle pulse at the end of traceback.
- path_len, out, PATH_W, number of moves accepted; held until the next start.
- error, out, 1, sticky illegal source code (3) seen; cleared on start.

Behaviour:
- Reset: every output is 0; the FSM goes to IDLE; the cur_row/cur_col registers are 0. Reset mid-traceback aborts immediately with no done pulse.
- FSM states and transitions:
  - IDLE: on start, latch cur_row = max_row, cur_col = max_col, clear path_len and error, go to READ. start in any other state is ignored.
  - READ: mem_rd_en = 1, mem_rd_addr = {cur_row, cur_col}, go to WAIT. mem_rd_en is high only in READ.
  - WAIT: register mem_rd_data.
    - zero_bit = 1 (MSB): go to DONE; this cell is not emitted.
    - source = 3: set error, go to DONE.
    - Otherwise go to EMIT.
  - EMIT: op_valid = 1; op_code, op_row and op_col stay stable until op_ready.
    - On op_valid & op_ready: increment path_len, then step the coordinates. Diagonal: row-1, col-1. Top: row-1. Left: col-1.
    - If the step would leave the matrix (row 0 with diagonal/top, or col 0 with diagonal/left), go to DONE without stepping. Otherwise go to READ.
  - DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- Throughput: 3 cycles per move with op_ready held high. Back-pressure stalls only EMIT; memory is not read while stalled.
- Latency examples: start in cycle 0 gives mem_rd_en in cycle 1 and op_valid in cycle 3.
- No arithmetic wrap: the boundary check precedes every decrement. path_len saturates at 2^PATH_W-1, which is unreachable for legal matrices.
- The max cell having zero_bit = 1 (all-zero matrix) gives done with path_len = 0 and no op_valid.

Test Plan:
- Diagonal run: max=(3,3); packets at (3,3), (2,2) and (1,1) are diagonal, (0,0) has zero_bit=1 → ops (3,3,0), (2,2,0), (1,1,0); done; path_len=3; read addrs 51, 34, 17, 0.
- Mixed path: max=(2,3); (2,3) left, (2,2) top, (1,2) diagonal, (0,1) zero → op_codes 2, 1, 0; path_len=3; final read addr 1.
- Boundary stop: max=(0,2); (0,2) left, (0,1) left, (0,0) left → 3 ops; done after the (0,0) op with no read below col 0.
- Back-pressure: op_ready low for 5 cycles on the first op → op_valid and fields held; no extra mem_rd_en; total latency grows by 5.
- Illegal/zero/restart:
  - Packet source=3 at the max cell → error=1, done, path_len=0.
  - Max cell with zero_bit=1 → done, path_len=0, no op_valid.
  - start while busy is ignored.
  - rst_n low in EMIT → all outputs 0, IDLE.
